// File: rtl/mux8_pkg.sv
// rtl/mux8_pkg.sv - shared types and constants for the 8:1 mux serializer
package mux8_pkg;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
    return msb_first ? SEL_W'(DATA_W - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
    return msb_first ? '0 : SEL_W'(DATA_W - 1);
  endfunction

endpackage

// File: rtl/mux8to1_bm.sv
// rtl/mux8to1_bm.sv - behavioural 8:1 single-bit multiplexer
module mux8to1_bm
  import mux8_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      3'd0: y = d[0];
      3'd1: y = d[1];
      3'd2: y = d[2];
      3'd3: y = d[3];
      3'd4: y = d[4];
      3'd5: y = d[5];
      3'd6: y = d[6];
      3'd7: y = d[7];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux8_serializer.sv
// rtl/mux8_serializer.sv - word-to-bit serializer stepping an 8:1 mux select
module mux8_serializer
  import mux8_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [SEL_W-1:0] FIRST = sel_first(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST  = sel_last(MSB_FIRST);
  // gap_cnt holds remaining GAP cycles minus one, so GAP lasts exactly GAP_CYCLES
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t             state;
  logic [DATA_W-1:0]  word_reg;
  logic [7:0]         gap_cnt;
  logic [SEL_W-1:0]   sel_step;

  assign sel_step = MSB_FIRST ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));

  mux8to1_bm u_mux (
    .d   (word_reg),
    .sel (sel),
    .y   (ser_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_reg  <= '0;
      sel       <= FIRST;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      in_ready  <= 1'b1;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            word_reg  <= in_data;
            sel       <= FIRST;
            state     <= SHIFT;
            in_ready  <= 1'b0;
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser_valid && ser_ready) begin
            if (sel == LAST) begin
              frame_cnt <= frame_cnt + CNT_W'(1);
              sel       <= FIRST;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
              if (GAP_CYCLES == 0) begin
                state    <= IDLE;
                in_ready <= 1'b1;
                busy     <= 1'b0;
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end
            end else begin
              sel      <= sel_step;
              ser_last <= (sel_step == LAST);
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          sel       <= FIRST;
          in_ready  <= 1'b1;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_serializer.sv
// tb/tb_mux8_serializer.sv - randomized and directed bench for mux8_serializer
module tb_mux8_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  in_valid = '0;
  logic [2:0]  ser_ready = '0;
  logic [23:0] in_data = '0;

  wire [2:0]  in_ready, ser_out, ser_valid, ser_last, busy;
  wire [8:0]  sel_v;
  wire [47:0] fc_v;

  wire [2:0]  e_ready, e_out, e_valid, e_last, e_busy;
  wire [8:0]  e_sel;
  wire [47:0] e_fc;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [7:0] seq, lm;
  int beats, fs, cnt;
  int exp6 [5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  mux8_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready[0]), .ser_last(ser_last[0]), .sel(sel_v[2:0]),
    .busy(busy[0]), .frame_cnt(fc_v[15:0]));

  mux8_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(3), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[15:8]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready[1]), .ser_last(ser_last[1]), .sel(sel_v[5:3]),
    .busy(busy[1]), .frame_cnt(fc_v[31:16]));

  mux8_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[23:16]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
    .ser_ready(ser_ready[2]), .ser_last(ser_last[2]), .sel(sel_v[8:6]),
    .busy(busy[2]), .frame_cnt(fc_v[33:32]));

  assign fc_v[47:34] = '0;

  // Transaction-level model: which word is held, how many of its bits went out, gap left
  for (genvar g = 0; g < 3; g++) begin : mdl
    localparam bit MSB  = (g == 1);
    localparam int GAPV = (g == 1) ? 3 : ((g == 2) ? 1 : 0);
    localparam int CW   = (g == 2) ? 2 : 16;
    logic [7:0] word;
    logic       shifting;
    int         idx, gap, frames;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word <= '0; shifting <= 1'b0; idx <= 0; gap <= 0; frames <= 0;
      end else if (shifting) begin
        if (ser_ready[g]) begin
          if (idx == 7) begin
            shifting <= 1'b0; frames <= frames + 1; gap <= GAPV;
          end else begin
            idx <= idx + 1;
          end
        end
      end else if (gap > 0) begin
        gap <= gap - 1;
      end else if (in_valid[g]) begin
        word <= in_data[8*g +: 8]; shifting <= 1'b1; idx <= 0;
      end
    end

    wire [2:0] pos  = MSB ? 3'(7 - idx) : 3'(idx);
    wire [2:0] esel = shifting ? pos : (MSB ? 3'd7 : 3'd0);
    assign e_sel[3*g +: 3]  = esel;
    assign e_out[g]         = word[esel];
    assign e_valid[g]       = shifting;
    assign e_last[g]        = shifting && (idx == 7);
    assign e_busy[g]        = shifting || (gap > 0);
    assign e_ready[g]       = !(shifting || (gap > 0));
    assign e_fc[16*g +: 16] = 16'(frames % (1 << CW));
  end

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready",  k, int'(in_ready[k]),  int'(e_ready[k]));
        chk("ser_valid", k, int'(ser_valid[k]), int'(e_valid[k]));
        chk("ser_last",  k, int'(ser_last[k]),  int'(e_last[k]));
        chk("busy",      k, int'(busy[k]),      int'(e_busy[k]));
        chk("sel",       k, int'(sel_v[3*k +: 3]), int'(e_sel[3*k +: 3]));
        chk("ser_out",   k, int'(ser_out[k]),   int'(e_out[k]));
        chk("frame_cnt", k, int'(fc_v[16*k +: 16]), int'(e_fc[16*k +: 16]));
      end
    end
  end

  // Call at a negedge; returns after the posedge that accepted the nbits-th beat
  task automatic send(input int k, input logic [7:0] d, input bit bp, input int nbits,
                      output logic [7:0] s, output int nb, output logic [7:0] lmask,
                      output int first_sel);
    int t;
    s = '0; nb = 0; lmask = '0; first_sel = -1; t = 0;
    while (!in_ready[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", k, int'(t < 200), 1);
    in_data[8*k +: 8] = d;
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[8*k +: 8] = 8'($urandom);
    t = 0;
    while (nb < nbits && t < 200) begin
      ser_ready[k] = !bp || (t % 3 == 0);
      if (ser_valid[k] && ser_ready[k]) begin
        if (nb == 0) first_sel = int'(sel_v[3*k +: 3]);
        s[nb]     = ser_out[k];
        lmask[nb] = ser_last[k];
        nb++;
      end
      @(negedge clk);
      t++;
    end
    ser_ready[k] = 1'b0;
    chk("beat_wait", k, int'(t < 200), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid  = 3'($urandom);
      ser_ready = 3'($urandom);
      in_data   = 24'($urandom);
      for (int k = 0; k < 3; k++) begin
        chk("rst_in_ready",  k, int'(in_ready[k]), 1);
        chk("rst_ser_valid", k, int'(ser_valid[k]), 0);
        chk("rst_busy",      k, int'(busy[k]), 0);
        chk("rst_frame_cnt", k, int'(fc_v[16*k +: 16]), 0);
      end
    end
    in_valid  = '0;
    ser_ready = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    send(0, 8'hA5, 1'b0, 8, seq, beats, lm, fs);
    chk("t2_seq",      0, int'(seq), 8'hA5);
    chk("t2_last",     0, int'(lm), 8'h80);
    chk("t2_in_ready", 0, int'(in_ready[0]), 1);
    chk("t2_frames",   0, int'(fc_v[15:0]), 1);

    send(0, 8'h3C, 1'b1, 8, seq, beats, lm, fs);
    chk("t3_seq",    0, int'(seq), 8'h3C);
    chk("t3_beats",  0, beats, 8);
    chk("t3_last",   0, int'(lm), 8'h80);
    chk("t3_frames", 0, int'(fc_v[15:0]), 2);

    send(1, 8'h81, 1'b0, 8, seq, beats, lm, fs);
    chk("t4_seq",       1, int'(seq), 8'h81);
    chk("t4_first_sel", 1, fs, 7);
    in_valid[1] = 1'b1;
    in_data[15:8] = 8'h00;
    cnt = 0;
    while (!in_ready[1] && cnt < 10) begin
      cnt++;
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    chk("t4_gap_len", 1, cnt, 3);
    chk("t4_hold",    1, int'(ser_out[1]), 1);
    @(negedge clk);
    chk("t4_not_taken", 1, int'(busy[1]), 0);

    send(0, 8'hFF, 1'b0, 4, seq, beats, lm, fs);
    chk("t5_partial", 0, beats, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_in_ready",  0, int'(in_ready[0]), 1);
    chk("t5_ser_valid", 0, int'(ser_valid[0]), 0);
    chk("t5_busy",      0, int'(busy[0]), 0);
    chk("t5_sel",       0, int'(sel_v[2:0]), 0);
    chk("t5_frames",    0, int'(fc_v[15:0]), 0);
    chk("t5_ser_out",   0, int'(ser_out[0]), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h01, 1'b0, 8, seq, beats, lm, fs);
    chk("t5_seq",       0, int'(seq), 8'h01);
    chk("t5_first_sel", 0, fs, 0);
    chk("t5_frames2",   0, int'(fc_v[15:0]), 1);

    for (int i = 0; i < 5; i++) begin
      send(2, 8'($urandom), 1'b0, 8, seq, beats, lm, fs);
      chk("t6_frames", 2, int'(fc_v[33:32]), exp6[i]);
    end

    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
      in_valid  = 3'($urandom);
      ser_ready = 3'($urandom) | 3'($urandom);
      in_data   = 24'($urandom);
    end
    @(negedge clk);
    in_valid  = '0;
    ser_ready = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
